// File: rtl/m3key_pkg.sv
// m3key_pkg: shared types and constants for the motor key conditioner.
// Holds the run FSM states, setpoint width and key vector indices.
package m3key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REV_WAIT
   } runState_e;

   localparam int SPD_W = 16;
   localparam int KEY_N = 5;

   localparam int K_START = 0;
   localparam int K_STOP  = 1;
   localparam int K_INV   = 2;
   localparam int K_INC   = 3;
   localparam int K_DEC   = 4;

endpackage

// File: rtl/m3key_debounce.sv
// m3key_debounce: 2-flop sync, debounce and press pulse for one key.
// Ports: clk, rst, keyRaw (active-low), keyHeld (accepted pressed),
//        keyPress (one cycle on accepted released-to-pressed).
module m3key_debounce
   import m3key_pkg::*;
#(
   parameter int unsigned DEB_CNT = 200000
) (
   input  logic clk,
   input  logic rst,
   input  logic keyRaw,
   output logic keyHeld,
   output logic keyPress
);

   localparam int CW = $clog2(DEB_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // level is the synced key in pressed-high form
   assign level = ~sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         cnt      <= '0;
         keyHeld  <= 1'b0;
         keyPress <= 1'b0;
      end else begin
         sync1    <= keyRaw;
         sync2    <= sync1;
         keyPress <= 1'b0;
         if (level == keyHeld) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // DEB_CNT consecutive differing cycles seen
            cnt      <= '0;
            keyHeld  <= level;
            keyPress <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/m3_key_cmd.sv
// m3_key_cmd: motor front-panel key conditioner (run/dir/speed cmd).
// Ports: clk, rst, five active-low raw keys; m3run, m3dir, m3speed,
//        m3cmdStb. Macro M3KEY_AUTOREPEAT_EN builds INC/DEC repeat.
module m3_key_cmd
   import m3key_pkg::*;
#(
   parameter int unsigned DEB_CNT  = 200000,
   parameter int unsigned REP_DLY  = 5000000,
   parameter int unsigned REP_PER  = 1000000,
   parameter int unsigned REV_GAP  = 1000000,
   parameter int unsigned SPD_MIN  = 1,
   parameter int unsigned SPD_MAX  = 1000,
   parameter int unsigned SPD_STEP = 1,
   parameter int unsigned SPD_INIT = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m3start,
   input  logic             m3forceStop,
   input  logic             m3invRotate,
   input  logic             m3freqINC,
   input  logic             m3freqDEC,
   output logic             m3run,
   output logic             m3dir,
   output logic [SPD_W-1:0] m3speed,
   output logic             m3cmdStb
);

   localparam int SW1 = SPD_W + 1;
   localparam int GW  = $clog2(REV_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(REV_GAP - 1);
   localparam logic [SPD_W:0] STEP_W = SW1'(SPD_STEP);
   localparam logic [SPD_W:0] MIN_W  = SW1'(SPD_MIN);
   localparam logic [SPD_W:0] MAX_W  = SW1'(SPD_MAX);

   logic [KEY_N-1:0] keyRaw;
   logic [KEY_N-1:0] held;
   logic [KEY_N-1:0] press;

   assign keyRaw = {m3freqDEC, m3freqINC, m3invRotate,
                    m3forceStop, m3start};

   for (genvar i = 0; i < KEY_N; i++) begin : gKey
      m3key_debounce #(
         .DEB_CNT(DEB_CNT)
      ) uDeb (
         .clk     (clk),
         .rst     (rst),
         .keyRaw  (keyRaw[i]),
         .keyHeld (held[i]),
         .keyPress(press[i])
      );
   end

   // ---------------- run FSM ----------------
   runState_e     state;
   logic [GW-1:0] gapCnt;
   logic          stopHeld;

   assign stopHeld = held[K_STOP];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         m3run  <= 1'b0;
         m3dir  <= 1'b0;
         gapCnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!stopHeld) begin
                  if (press[K_START]) begin
                     state <= RUN;
                     m3run <= 1'b1;
                  end else if (press[K_INV]) begin
                     m3dir <= ~m3dir;
                  end
               end
            end
            RUN: begin
               if (stopHeld) begin
                  state <= IDLE;
                  m3run <= 1'b0;
               end else if (press[K_INV]) begin
                  state  <= REV_WAIT;
                  m3run  <= 1'b0;
                  gapCnt <= '0;
               end
            end
            REV_WAIT: begin
               if (stopHeld) begin
                  // abandon reversal, direction kept
                  state  <= IDLE;
                  gapCnt <= '0;
               end else if (gapCnt == GAP_LAST) begin
                  state  <= RUN;
                  m3run  <= 1'b1;
                  m3dir  <= ~m3dir;
                  gapCnt <= '0;
               end else begin
                  gapCnt <= gapCnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               m3run <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- speed setpoint ----------------
   logic [1:0]     tick;
   logic           incStep;
   logic           decStep;
   logic           clash;
   logic           doInc;
   logic           doDec;
   logic [SPD_W:0] spdWide;
   logic [SPD_W:0] spdSum;
   logic [SPD_W:0] spdUp;
   logic [SPD_W:0] spdDn;

   assign incStep = press[K_INC] | tick[0];
   assign decStep = press[K_DEC] | tick[1];
   // opposing keys cancel and restart the repeat timers
   assign clash   = (held[K_INC] & held[K_DEC])
                  | (incStep & decStep);
   assign doInc   = incStep & ~clash;
   assign doDec   = decStep & ~clash;

   // one extra bit so the sum never wraps before clamping
   assign spdWide = {1'b0, m3speed};
   assign spdSum  = spdWide + STEP_W;
   assign spdUp   = (spdSum > MAX_W) ? MAX_W : spdSum;
   assign spdDn   = (spdWide < MIN_W + STEP_W) ? MIN_W
                                               : spdWide - STEP_W;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m3speed <= SPD_W'(SPD_INIT);
      end else begin
         unique case (1'b1)
            doInc:   m3speed <= spdUp[SPD_W-1:0];
            doDec:   m3speed <= spdDn[SPD_W-1:0];
            default: m3speed <= m3speed;
         endcase
      end
   end

`ifdef M3KEY_AUTOREPEAT_EN
   localparam int RMX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int RW  = $clog2(RMX + 1);
   localparam logic [RW-1:0] DLY_W = RW'(REP_DLY);
   localparam logic [RW-1:0] PER_W = RW'(REP_PER);

   logic [1:0]    rpHeld;
   logic [1:0]    rpPress;
   logic [1:0]    rpFirst;
   logic [RW-1:0] rpCnt [2];

   assign rpHeld  = {held[K_DEC], held[K_INC]};
   assign rpPress = {press[K_DEC], press[K_INC]};

   // rpCnt equals cycles since press (or since last tick)
   always_comb begin
      tick = 2'b00;
      for (int k = 0; k < 2; k++) begin
         tick[k] = rpHeld[k] & ~rpPress[k]
                 & (rpCnt[k] == (rpFirst[k] ? DLY_W : PER_W));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            rpCnt[k]   <= '0;
            rpFirst[k] <= 1'b1;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!rpHeld[k] || clash) begin
               rpCnt[k]   <= '0;
               rpFirst[k] <= 1'b1;
            end else if (rpPress[k]) begin
               rpCnt[k]   <= RW'(1);
               rpFirst[k] <= 1'b1;
            end else if (tick[k]) begin
               rpCnt[k]   <= RW'(1);
               rpFirst[k] <= 1'b0;
            end else begin
               rpCnt[k] <= rpCnt[k] + 1'b1;
            end
         end
      end
   end
`else
   logic unusedRep;

   assign tick      = 2'b00;
   assign unusedRep = ^{REP_DLY[0], REP_PER[0]};
`endif

   // ---------------- change strobe ----------------
   logic             runQ;
   logic             dirQ;
   logic [SPD_W-1:0] spdQ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runQ     <= 1'b0;
         dirQ     <= 1'b0;
         spdQ     <= SPD_W'(SPD_INIT);
         m3cmdStb <= 1'b0;
      end else begin
         runQ     <= m3run;
         dirQ     <= m3dir;
         spdQ     <= m3speed;
         m3cmdStb <= (m3run != runQ) | (m3dir != dirQ)
                   | (m3speed != spdQ);
      end
   end

   logic unusedKeys;

   assign unusedKeys = ^{held[K_START], held[K_INV],
                         press[K_STOP], spdUp[SPD_W],
                         spdDn[SPD_W]};

endmodule

// File: tb/tb_m3_key_cmd.sv
// tb_m3_key_cmd: directed plus randomized checks of m3_key_cmd.
// Speed keys are checked against an event-level setpoint model.
module tb_m3_key_cmd;

   localparam int DEB  = 4;
   localparam int RDLY = 20;
   localparam int RPER = 5;
   localparam int RGAP = 10;
   localparam int SMIN = 1;
   localparam int SMAX = 105;
   localparam int SINI = 100;
   localparam int STEP = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        kStart;
   logic        kStop;
   logic        kInv;
   logic        kInc;
   logic        kDec;
   logic        m3run;
   logic        m3dir;
   logic [15:0] m3speed;
   logic        m3cmdStb;

   int checks = 0;
   int errors = 0;
   int stbCnt = 0;

   m3_key_cmd #(
      .DEB_CNT (DEB),
      .REP_DLY (RDLY),
      .REP_PER (RPER),
      .REV_GAP (RGAP),
      .SPD_MIN (SMIN),
      .SPD_MAX (SMAX),
      .SPD_STEP(STEP),
      .SPD_INIT(SINI)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m3start    (kStart),
      .m3forceStop(kStop),
      .m3invRotate(kInv),
      .m3freqINC  (kInc),
      .m3freqDEC  (kDec),
      .m3run      (m3run),
      .m3dir      (m3dir),
      .m3speed    (m3speed),
      .m3cmdStb   (m3cmdStb)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (m3cmdStb === 1'b1) stbCnt++;
   end

   task automatic chk(input string tag, input int obs,
                      input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // steps produced by one clean hold of h accepted cycles
   function automatic int nSteps(input int h);
      int n;
      n = 1;
`ifdef M3KEY_AUTOREPEAT_EN
      if (h > RDLY) n += (h - RDLY - 1) / RPER + 1;
`endif
      return n;
   endfunction

   int mSpd;
   int mStb;

   task automatic applySteps(input int up, input int n);
      int nv;
      for (int s = 0; s < n; s++) begin
         nv = up ? mSpd + STEP : mSpd - STEP;
         if (nv > SMAX) nv = SMAX;
         if (nv < SMIN) nv = SMIN;
         if (nv != mSpd) mStb++;
         mSpd = nv;
      end
   endtask

   int base;
   int k;
   int h;

   initial begin
      rst    = 1'b1;
      kStart = 1'b1;
      kStop  = 1'b1;
      kInv   = 1'b1;
      kInc   = 1'b1;
      kDec   = 1'b1;
      mSpd   = SINI;
      cyc(3);
      chk("rst_run", m3run, 0);
      chk("rst_dir", m3dir, 0);
      chk("rst_spd", m3speed, SINI);
      chk("rst_stb", m3cmdStb, 0);
      rst = 1'b0;
      cyc(3);

      // bounce then stable low on start
      base = stbCnt;
      for (int i = 0; i < 10; i++) begin
         kStart = (i % 2 == 1);
         cyc(2);
      end
      chk("bounce_norun", m3run, 0);
      kStart = 1'b0;
      cyc(6);
      chk("bounce_run6", m3run, 0);
      cyc(1);
      chk("bounce_run7", m3run, 1);
      cyc(2);
      chk("bounce_stb", stbCnt - base, 1);
      kStart = 1'b1;
      cyc(10);

      // reversal from RUN
      base = stbCnt;
      kInv = 1'b0;
      cyc(7);
      chk("rev_fall", m3run, 0);
      kInv = 1'b1;
      cyc(9);
      chk("rev_gap_run", m3run, 0);
      chk("rev_gap_dir", m3dir, 0);
      cyc(1);
      chk("rev_end_run", m3run, 1);
      chk("rev_end_dir", m3dir, 1);
      cyc(10);
      chk("rev_stb", stbCnt - base, 2);

      // INC held 60 cycles
      base = stbCnt;
      kInc = 1'b0;
      cyc(60);
      kInc = 1'b1;
      cyc(12);
`ifdef M3KEY_AUTOREPEAT_EN
      chk("inc60_spd", m3speed, 105);
      chk("inc60_stb", stbCnt - base, 5);
      mSpd = 105;
`else
      chk("inc60_spd", m3speed, 101);
      chk("inc60_stb", stbCnt - base, 1);
      mSpd = 101;
`endif

      // random clean INC/DEC holds vs event model
      base = stbCnt;
      mStb = 0;
      for (int e = 0; e < 10; e++) begin
         k = $urandom_range(0, 1);
         h = $urandom_range(DEB + 1, 45);
         if (k == 0) kInc = 1'b0;
         else        kDec = 1'b0;
         cyc(h);
         kInc = 1'b1;
         kDec = 1'b1;
         cyc(12);
         applySteps(k == 0, nSteps(h));
         chk($sformatf("rnd%0d_spd", e), m3speed, mSpd);
      end
      chk("rnd_stb", stbCnt - base, mStb);

      // INC and DEC together
      base = stbCnt;
      kInc = 1'b0;
      kDec = 1'b0;
      cyc(40);
      chk("both_hold_spd", m3speed, mSpd);
      kInc = 1'b1;
      kDec = 1'b1;
      cyc(12);
      chk("both_spd", m3speed, mSpd);
      chk("both_stb", stbCnt - base, 0);

      // forceStop from RUN, then stop+start together
      kStop = 1'b0;
      cyc(8);
      chk("stop_idle", m3run, 0);
      kStop = 1'b1;
      cyc(10);
      kStop  = 1'b0;
      kStart = 1'b0;
      cyc(20);
      chk("prio_hold", m3run, 0);
      kStop  = 1'b1;
      kStart = 1'b1;
      cyc(10);
      chk("prio_after", m3run, 0);

      // invRotate in IDLE toggles direction
      kInv = 1'b0;
      cyc(8);
      chk("idle_inv_dir", m3dir, 0);
      chk("idle_inv_run", m3run, 0);
      kInv = 1'b1;
      cyc(10);

      // forceStop during REV_WAIT
      kStart = 1'b0;
      cyc(8);
      chk("start2_run", m3run, 1);
      kStart = 1'b1;
      cyc(8);
      kInv = 1'b0;
      cyc(7);
      chk("rw_fall", m3run, 0);
      kStop = 1'b0;
      cyc(14);
      chk("rw_stop_run", m3run, 0);
      chk("rw_stop_dir", m3dir, 0);
      kInv  = 1'b1;
      kStop = 1'b1;
      cyc(12);
      chk("rw_idle_run", m3run, 0);
      chk("rw_idle_dir", m3dir, 0);

      // reset in the middle of REV_WAIT
      kStart = 1'b0;
      cyc(8);
      kStart = 1'b1;
      cyc(8);
      kInv = 1'b0;
      cyc(17);
      chk("rs_pre_dir", m3dir, 1);
      kInv = 1'b1;
      cyc(10);
      kInv = 1'b0;
      cyc(7);
      chk("rs_pre_run", m3run, 0);
      rst = 1'b1;
      #1;
      chk("rs_run", m3run, 0);
      chk("rs_dir", m3dir, 0);
      chk("rs_spd", m3speed, SINI);
      chk("rs_stb", m3cmdStb, 0);
      kInv   = 1'b1;
      kStart = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(6);
      chk("rs_held_run6", m3run, 0);
      cyc(1);
      chk("rs_held_run7", m3run, 1);
      kStart = 1'b1;
      cyc(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
